// File: rtl/qcore_wave_dispatch_pkg.sv
// Shared definitions for the wave-port dispatcher: wave word layout and FSM states.
package qcore_wave_dispatch_pkg;

    localparam int WAVE_W = 168;

    // Wave word field slices, identical to the core wave register layout.
    localparam int WAVE_FREQ_LSB   = 0;
    localparam int WAVE_FREQ_W     = 32;
    localparam int WAVE_PHASE_LSB  = 32;
    localparam int WAVE_PHASE_W    = 32;
    localparam int WAVE_ENV_LSB    = 64;
    localparam int WAVE_ENV_W      = 24;
    localparam int WAVE_GAIN_LSB   = 88;
    localparam int WAVE_GAIN_W     = 32;
    localparam int WAVE_LENGTH_LSB = 120;
    localparam int WAVE_LENGTH_W   = 32;
    localparam int WAVE_CONF_LSB   = 152;
    localparam int WAVE_CONF_W     = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2
    } disp_state_e;

endpackage

// File: rtl/qcore_wave_fifo.sv
// Synchronous FIFO with registered read data, occupancy count and full flag.
module qcore_wave_fifo #(
    parameter int AW = 3,
    parameter int W  = 200
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          wr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_i,
    output logic [W-1:0]  rd_data_o,
    output logic [AW:0]   cnt_o,
    output logic          full_o
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full_o = (cnt_o == (AW + 1)'(DEPTH));
    assign rd_en  = rd_i & (cnt_o != '0) & ~clear_i;
    // A write into a full memory is allowed when a read frees a slot in the same cycle.
    assign wr_en  = wr_i & ~clear_i & (~full_o | rd_en);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_o  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_o  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt_o <= cnt_o + (AW + 1)'(1);
                2'b01:   cnt_o <= cnt_o - (AW + 1)'(1);
                default: cnt_o <= cnt_o;
            endcase
        end
    end

    // NOTE: storage has no reset so it maps onto RAM; validity is tracked by cnt_o alone.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= wr_data_i;
        if (rd_en) rd_data_o <= mem[rd_ptr];
    end

endmodule

// File: rtl/qcore_wave_dispatch.sv
// Timed wave-port dispatcher: queues (time, wave) pairs and releases the head
// entry to the signal-generator port once the timeline reaches its time.
module qcore_wave_dispatch
    import qcore_wave_dispatch_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int TIME_W  = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                push_i,
    input  logic [TIME_W-1:0]   push_time_i,
    input  logic [WAVE_W-1:0]   push_wave_i,
    input  logic [TIME_W-1:0]   time_abs_i,
    input  logic                time_en_i,
    output logic                wave_we_o,
    output logic [WAVE_W-1:0]   wave_dt_o,
    output logic [FIFO_AW:0]    lvl_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                late_o,
    output logic                ovf_o
);

    localparam int ENT_W = TIME_W + WAVE_W;

    disp_state_e         state_q, state_d;
    logic                mem_rd;
    logic                mem_full;
    logic [FIFO_AW:0]    mem_cnt;
    logic [ENT_W-1:0]    rd_data;
    logic                head_valid;
    logic [TIME_W-1:0]   head_time;
    logic [WAVE_W-1:0]   head_wave;
    logic [TIME_W-1:0]   diff;
    logic                diff_neg;
    logic                fire;
    logic                drop;

    qcore_wave_fifo #(
        .AW (FIFO_AW),
        .W  (ENT_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .wr_i      (push_i),
        .wr_data_i ({push_time_i, push_wave_i}),
        .rd_i      (mem_rd),
        .rd_data_o (rd_data),
        .cnt_o     (mem_cnt),
        .full_o    (mem_full)
    );

    // Two's-complement difference keeps the compare correct across timeline wrap.
    assign diff     = head_time - time_abs_i;
    assign diff_neg = diff[TIME_W-1];
    assign fire     = time_en_i & head_valid & (state_q == WAIT) & (diff_neg | (diff == '0));
    assign drop     = push_i & ~clear_i & mem_full & ~mem_rd;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        mem_rd  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (mem_cnt != '0) begin
                    mem_rd  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = WAIT;
            WAIT: begin
                if (fire) begin
                    if (mem_cnt != '0) begin
                        mem_rd  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        if (clear_i) begin
            state_d = EMPTY;
            mem_rd  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= EMPTY;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_valid <= 1'b0;
            head_time  <= '0;
            head_wave  <= '0;
            wave_we_o  <= 1'b0;
            wave_dt_o  <= '0;
            late_o     <= 1'b0;
            ovf_o      <= 1'b0;
        end else if (clear_i) begin
            // wave_dt_o deliberately keeps the last dispatched word.
            head_valid <= 1'b0;
            wave_we_o  <= 1'b0;
            late_o     <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            wave_we_o <= fire;
            if (fire) begin
                wave_dt_o  <= head_wave;
                head_valid <= 1'b0;
                if (diff_neg) late_o <= 1'b1;
            end
            if (state_q == LOAD) begin
                head_time  <= rd_data[ENT_W-1 -: TIME_W];
                head_wave  <= rd_data[WAVE_W-1:0];
                head_valid <= 1'b1;
            end
            if (drop) ovf_o <= 1'b1;
        end
    end

    assign lvl_o   = mem_cnt + (FIFO_AW + 1)'(head_valid);
    assign full_o  = mem_full;
    assign empty_o = (lvl_o == '0);

endmodule

// File: tb/tb_qcore_wave_dispatch.sv
// Scenario bench for qcore_wave_dispatch: expected dispatches are queued when
// entries are pushed and matched against each wave_we_o pulse.
module tb_qcore_wave_dispatch;

    localparam int TW = 32;
    localparam int WW = 168;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           clear_i;
    logic           push_i;
    logic [TW-1:0]  push_time_i;
    logic [WW-1:0]  push_wave_i;
    logic [TW-1:0]  time_abs_i;
    logic           time_en_i;
    logic           wave_we_o;
    logic [WW-1:0]  wave_dt_o;
    logic [3:0]     lvl_o;
    logic           full_o;
    logic           empty_o;
    logic           late_o;
    logic           ovf_o;

    typedef struct {
        logic [WW-1:0] wave;
        logic [TW-1:0] abs_t;
        logic          late;
    } exp_t;

    exp_t          sb[$];
    int            vectors = 0;
    int            errors  = 0;
    int            pulses  = 0;
    bit            advance = 1'b0;
    logic [WW-1:0] last_wave = '0;

    qcore_wave_dispatch #(.FIFO_AW(3), .TIME_W(TW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (push_i),
        .push_time_i (push_time_i),
        .push_wave_i (push_wave_i),
        .time_abs_i  (time_abs_i),
        .time_en_i   (time_en_i),
        .wave_we_o   (wave_we_o),
        .wave_dt_o   (wave_dt_o),
        .lvl_o       (lvl_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .late_o      (late_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [WW-1:0] mk_wave();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[WW-1:0];
    endfunction

    // One clock: sample outputs 1 time unit after the edge and score any dispatch.
    task automatic step();
        logic [TW-1:0] prev_abs;
        exp_t          e;
        prev_abs = time_abs_i;
        @(posedge clk_i);
        #1;
        if (wave_we_o) begin
            pulses++;
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got pulse at time_abs=%0d, required none", prev_abs);
            end else begin
                e = sb.pop_front();
                if (wave_dt_o !== e.wave) begin
                    errors++;
                    $display("FAIL wave_dt: got %h, required %h", wave_dt_o, e.wave);
                end
                vectors++;
                if (prev_abs !== e.abs_t) begin
                    errors++;
                    $display("FAIL fire_time: fired after time_abs=%0d, required %0d", prev_abs, e.abs_t);
                end
                vectors++;
                if (late_o !== e.late) begin
                    errors++;
                    $display("FAIL late_at_fire: got %b, required %b", late_o, e.late);
                end
                last_wave = e.wave;
            end
        end
        if (advance) time_abs_i = time_abs_i + 1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d dispatches pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic push(input logic [TW-1:0] t, input logic [WW-1:0] w);
        push_i      = 1'b1;
        push_time_i = t;
        push_wave_i = w;
        step();
        push_i      = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; push_i = 1'b0; push_time_i = '0;
        push_wave_i = '0; time_abs_i = '0; time_en_i = 1'b0; advance = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step();
        vectors++;
        if ({wave_we_o, lvl_o, full_o, late_o, ovf_o} !== 8'b0 || wave_dt_o !== '0 || empty_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: we=%b lvl=%0d full=%b late=%b ovf=%b empty=%b, required 0/0/0/0/0/1",
                     wave_we_o, lvl_o, full_o, late_o, ovf_o, empty_o);
        end
    endtask

    task automatic test_single();
        logic [WW-1:0] w;
        int p0;
        w = mk_wave();
        p0 = pulses;
        time_abs_i = '0; time_en_i = 1'b1; advance = 1'b1;
        sb.push_back('{w, 32'd100, 1'b0});
        push(32'd100, w);
        drain(200);
        repeat (5) step();
        vectors++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL single_pulse_count: got %0d, required 1", pulses - p0);
        end
        vectors++;
        if (late_o !== 1'b0) begin
            errors++;
            $display("FAIL single_late: got %b, required 0", late_o);
        end
    endtask

    task automatic test_three_in_order();
        logic [WW-1:0] w;
        int p0;
        do_clear();
        advance = 1'b0; time_abs_i = '0; time_en_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            w = mk_wave();
            sb.push_back('{w, TW'(10 * i), 1'b0});
            push(TW'(10 * i), w);
        end
        repeat (3) step();
        vectors++;
        if (lvl_o !== 4'd3) begin
            errors++;
            $display("FAIL three_lvl_start: got %0d, required 3", lvl_o);
        end
        advance = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            p0 = pulses;
            while (pulses == p0 && n < 60) begin
                step();
                n++;
            end
            repeat (2) step();
            vectors++;
            if (lvl_o !== 4'(2 - k)) begin
                errors++;
                $display("FAIL three_lvl_after_%0d: got %0d, required %0d", k, lvl_o, 2 - k);
            end
        end
        drain(10);
    endtask

    task automatic test_past_entry();
        logic [WW-1:0] w;
        int p0;
        do_clear();
        advance = 1'b0; time_abs_i = 32'd50; time_en_i = 1'b1;
        w = mk_wave();
        sb.push_back('{w, 32'd50, 1'b1});
        push(32'd5, w);
        p0 = pulses;
        repeat (2) step();
        vectors++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL past_early: got %0d pulses before WAIT, required 0", pulses - p0);
        end
        step();
        vectors++;
        if (pulses != p0 + 1) begin
            errors++;
            $display("FAIL past_first_wait: got %0d pulses, required 1", pulses - p0);
        end
        repeat (5) step();
        vectors++;
        if (late_o !== 1'b1) begin
            errors++;
            $display("FAIL past_late_sticky: got %b, required 1", late_o);
        end
        do_clear();
        vectors++;
        if (late_o !== 1'b0) begin
            errors++;
            $display("FAIL past_late_clear: got %b, required 0", late_o);
        end
        drain(5);
    endtask

    task automatic test_wrap();
        logic [WW-1:0] w;
        do_clear();
        advance = 1'b1; time_abs_i = 32'hFFFF_FFF0; time_en_i = 1'b1;
        w = mk_wave();
        sb.push_back('{w, 32'h0000_0010, 1'b0});
        push(32'h0000_0010, w);
        drain(100);
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] w1, w2;
        do_clear();
        advance = 1'b0; time_abs_i = 32'd150; time_en_i = 1'b1;
        w1 = mk_wave();
        w2 = mk_wave();
        sb.push_back('{w1, 32'd200, 1'b0});
        sb.push_back('{w2, 32'd202, 1'b1});
        push(32'd200, w1);
        push(32'd201, w2);
        advance = 1'b1;
        drain(120);
    endtask

    task automatic test_enable_hold();
        logic [WW-1:0] w;
        int n = 0;
        do_clear();
        advance = 1'b1; time_abs_i = '0; time_en_i = 1'b0;
        w = mk_wave();
        push(32'd40, w);
        while (time_abs_i != 32'd60 && n < 100) begin
            step();
            n++;
        end
        sb.push_back('{w, 32'd60, 1'b1});
        time_en_i = 1'b1;
        drain(5);
    endtask

    task automatic test_overflow_clear();
        int p0;
        logic [WW-1:0] keep;
        do_clear();
        keep = last_wave;
        advance = 1'b0; time_abs_i = '0; time_en_i = 1'b0;
        for (int i = 0; i < 10; i++) push(TW'(1000 + i), mk_wave());
        vectors++;
        if (lvl_o !== 4'd9 || full_o !== 1'b1 || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state: lvl=%0d full=%b ovf=%b, required 9/1/1", lvl_o, full_o, ovf_o);
        end
        do_clear();
        vectors++;
        if (lvl_o !== 4'd0 || full_o !== 1'b0 || ovf_o !== 1'b0 || late_o !== 1'b0 || empty_o !== 1'b1) begin
            errors++;
            $display("FAIL clear_state: lvl=%0d full=%b ovf=%b late=%b empty=%b, required 0/0/0/0/1",
                     lvl_o, full_o, ovf_o, late_o, empty_o);
        end
        vectors++;
        if (wave_dt_o !== keep) begin
            errors++;
            $display("FAIL clear_keeps_dt: got %h, required %h", wave_dt_o, keep);
        end
        p0 = pulses;
        time_abs_i = 32'd5000; time_en_i = 1'b1; advance = 1'b1;
        repeat (20) step();
        vectors++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL post_clear_pulses: got %0d, required 0", pulses - p0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_in_order();
        test_past_entry();
        test_wrap();
        test_back_to_back();
        test_enable_hold();
        test_overflow_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/qcore_wave_dispatch.md
Name: qcore_wave_dispatch

Overview:
- Timed wave-port dispatcher. It consumes the 168-bit wave parameter word and 32-bit scheduled time that the core register bank presents on its wave/time outputs.
- Buffers each (time, wave) pair in a small FIFO.
- Releases the head entry to a signal-generator port when the running timeline reaches the scheduled time.
- Sits between the tProcessor core and one wave output port; one instance per port.

Parameters:
- FIFO_AW, 3, FIFO address width; memory depth DEPTH = 2**FIFO_AW entries.
- TIME_W, 32, timestamp width; must match the core time register width.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush; same semantics as the core clear.
- push_i  in  1  core write strobe: enqueue one entry.
- push_time_i  in  TIME_W  scheduled dispatch time for the entry.
- push_wave_i  in  168  wave word; field packing is identical to the core wave register layout.
- time_abs_i  in  TIME_W  current timeline count.
- time_en_i  in  1  timeline running; dispatch is allowed only when high.
- wave_we_o  out  1  one-cycle strobe: wave_dt_o is new.
- wave_dt_o  out  168  dispatched wave word; holds its value between strobes.
- lvl_o  out  FIFO_AW+1  occupancy = FIFO memory entries + head-register valid.
- full_o  out  1  FIFO memory holds DEPTH entries.
- empty_o  out  1  lvl_o == 0.
- late_o  out  1  sticky: at least one entry was dispatched after its time.
- ovf_o  out  1  sticky: at least one push was dropped.

Behaviour:
- Reset: all outputs 0, FIFO pointers 0, head invalid, FSM in EMPTY.
- Storage: FIFO memory uses a registered (synchronous) read. The head register holds the entry currently being compared.
- Push: accepted when mem_cnt < DEPTH, or when a memory read occurs in the same cycle.
  - Otherwise the entry is dropped and ovf_o is set.
  - A simultaneous push and read leaves mem_cnt unchanged.
  - Pointers wrap modulo DEPTH.
- Time compare: diff = head_time - time_abs_i, computed as TIME_W-bit signed (two's complement). This makes timeline wrap-around transparent.
  - fire = time_en_i & head_valid & (diff <= 0).
- FSM states:
  - EMPTY: head invalid. If mem_cnt > 0, issue memory read and go to LOAD.
  - LOAD: capture read data into the head register, set head valid, go to WAIT.
  - WAIT: evaluate fire every cycle.
    - While not firing, stay in WAIT.
    - On fire: register wave_dt_o <= head_wave, pulse wave_we_o on the next cycle, clear head valid.
    - If diff < 0 at fire, set late_o.
    - Then, if mem_cnt > 0, issue a read and go to LOAD; else go to EMPTY.
- Latency:
  - wave_we_o rises exactly 1 cycle after the cycle in which time_abs_i == head_time.
  - Push into an empty block to head valid takes 2 cycles (EMPTY→LOAD→WAIT).
  - Maximum throughput is one dispatch per 2 cycles; entries spaced by 1 tick are dispatched late and flag late_o.
- Entry already in the past when it reaches head: fires on the first WAIT cycle with time_en_i high, and sets late_o.
- time_en_i low: no fire; FSM holds in WAIT, and pushes continue to be accepted.
- clear_i (priority over push and fire):
  - Pointers and mem_cnt to 0, head invalid, FSM to EMPTY.
  - late_o, ovf_o and wave_we_o to 0.
  - wave_dt_o keeps its last value.
  - A push in the same cycle as clear_i is discarded and does not set ovf_o.
- Asynchronous reset mid-operation discards all queued entries; there is no partial dispatch.

Decomposition:
- Shared package (qick defines) holds:
  - WAVE_W = 168;
  - the wave field offsets (gain/freq/phase/env/length/conf slices matching the register bank);
  - the FSM enum {EMPTY, LOAD, WAIT}.
- One natural sub-module: qcore_wave_fifo, a parameterised synchronous FIFO with registered read, count and full/empty flags. Width = TIME_W + 168.

Test Plan:
1. Reset, then push time=100 with a wave pattern, time_en_i=1, time_abs_i counting from 0 → exactly one wave_we_o pulse at the cycle after time_abs_i=100; wave_dt_o equals the pattern; late_o=0.
2. Push times 10, 20, 30 at time_abs_i=0 → three pulses, one cycle after 10, 20 and 30 respectively, in order; lvl_o goes 3→2→1→0.
3. Push time=5 when time_abs_i=50 → pulse at the first WAIT cycle; late_o=1 and stays set until clear_i.
4. Wrap: time_abs_i=0xFFFF_FFF0, push time=0x0000_0010 → no early fire; pulse one cycle after time_abs_i=0x10.
5. With FIFO_AW=3 and time_en_i=0, push 10 entries → first entry in head, next 8 in memory, full_o=1, 10th dropped, ovf_o=1, lvl_o=9; then assert clear_i → lvl_o=0, flags 0, no pulses afterwards.
6. Hold time_en_i=0 while time_abs_i passes the head time of 40, then raise it at time_abs_i=60 → pulse 1 cycle later and late_o=1.
